// File: rtl/da_serial_driver.sv
// Bit-serial offset-binary DA driver: walks A bit-slices MSB-first, drives LUT addresses
// and shift-accumulates signed partial sums. Optional correction step: DA_DRV_CORR_EN.
module da_serial_driver #(
    parameter int DATA_WIDTH_A = 8,
    parameter int DATA_WIDTH_B = 8,
    parameter int K            = 4,
    parameter int LUT_WIDTH    = DATA_WIDTH_B + $clog2(K),
    parameter int ACC_WIDTH    = LUT_WIDTH + DATA_WIDTH_A + 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DATA_WIDTH_A-1:0] A_in [K],
    input  logic signed [LUT_WIDTH:0]      b_half_sum,
    output logic                           gen_done,
    output logic [K-2:0]                   addr_array,
    input  logic signed [LUT_WIDTH:0]      LUT_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [ACC_WIDTH-1:0]    result
);

    localparam int W     = DATA_WIDTH_A;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [W-1:0]                a_sr_q [K];
    logic [W-1:0]                a_sr_d [K];
    logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

    logic [K-1:0]                slice;
    logic [K-2:0]                addr_run;
    logic signed [ACC_WIDTH-1:0] lut_ext;
    logic signed [ACC_WIDTH-1:0] p_val;

`ifdef DA_DRV_CORR_EN
    logic signed [LUT_WIDTH:0]   bhs_q, bhs_d;
    logic signed [ACC_WIDTH-1:0] bhs_ext;

    assign bhs_ext = {{(ACC_WIDTH-LUT_WIDTH-1){bhs_q[LUT_WIDTH]}}, bhs_q};
`else
    logic unused_bhs;

    assign unused_bhs = ^b_half_sum;
`endif

    // Element 0's bit is hardwired to 1 inside the LUT, so the others are encoded relative to it
    always_comb begin
        for (int unsigned i = 0; i < K; i++) begin
            slice[i] = a_sr_q[i][W-1];
        end
        for (int unsigned i = 1; i < K; i++) begin
            addr_run[i-1] = ~(slice[i] ^ slice[0]);
        end
    end

    assign lut_ext = {{(ACC_WIDTH-LUT_WIDTH-1){LUT_out[LUT_WIDTH]}}, LUT_out};
    assign p_val   = slice[0] ? lut_ext : -lut_ext;
    assign result  = acc_q;

    always_comb begin
        state_d    = state_q;
        a_sr_d     = a_sr_q;
        bit_cnt_d  = bit_cnt_q;
        acc_d      = acc_q;
`ifdef DA_DRV_CORR_EN
        bhs_d      = bhs_q;
`endif
        in_ready   = 1'b0;
        gen_done   = 1'b0;
        addr_array = '0;
        out_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int unsigned i = 0; i < K; i++) begin
                        a_sr_d[i] = A_in[i];
                    end
`ifdef DA_DRV_CORR_EN
                    bhs_d = b_half_sum;
`endif
                    bit_cnt_d = CNT_MAX;
                    state_d   = RUN;
                end
            end
            RUN: begin
                gen_done   = 1'b1;
                addr_array = addr_run;
                // The MSB slice carries negative (sign-bit) weight in two's complement
                if (bit_cnt_q == CNT_MAX) begin
                    acc_d = -p_val;
                end else begin
                    acc_d = (acc_q <<< 1) + p_val;
                end
                for (int unsigned i = 0; i < K; i++) begin
                    a_sr_d[i] = a_sr_q[i] << 1;
                end
                bit_cnt_d = bit_cnt_q - CNT_W'(1);
                if (bit_cnt_q == '0) begin
`ifdef DA_DRV_CORR_EN
                    state_d = FIX;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef DA_DRV_CORR_EN
            FIX: begin
                acc_d   = acc_q - bhs_ext;
                state_d = DONE;
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            acc_q     <= '0;
            for (int unsigned i = 0; i < K; i++) begin
                a_sr_q[i] <= '0;
            end
`ifdef DA_DRV_CORR_EN
            bhs_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            acc_q     <= acc_d;
            for (int unsigned i = 0; i < K; i++) begin
                a_sr_q[i] <= a_sr_d[i];
            end
`ifdef DA_DRV_CORR_EN
            bhs_q     <= bhs_d;
`endif
        end
    end

endmodule

// File: tb/tb_da_serial_driver.sv
// Directed bench for da_serial_driver with a behavioural offset-binary LUT (K=4, W=8).
module tb_da_serial_driver;

    localparam int W = 8;
`ifdef DA_DRV_CORR_EN
    localparam int LAT  = W + 2;
    localparam int CORR = 1;
`else
    localparam int LAT  = W + 1;
    localparam int CORR = 0;
`endif

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  A_in [4];
    logic signed [10:0] b_half_sum;
    logic               gen_done;
    logic [2:0]         addr_array;
    logic signed [10:0] lut_out;
    logic               out_valid;
    logic               out_ready;
    logic signed [19:0] result;

    logic signed [7:0]  b_cur [4];
    int                 lut_sum;

    int checks = 0;
    int errors = 0;

    da_serial_driver #(
        .DATA_WIDTH_A(8),
        .DATA_WIDTH_B(8),
        .K(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A_in(A_in),
        .b_half_sum(b_half_sum),
        .gen_done(gen_done),
        .addr_array(addr_array),
        .LUT_out(lut_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LUT: element 0 always +B0/2, element i is +B_i/2 when its address bit is 1, else -B_i/2
    always_comb begin
        lut_sum = int'(b_cur[0]) >>> 1;
        for (int i = 1; i < 4; i++) begin
            if (addr_array[i-1]) lut_sum = lut_sum + (int'(b_cur[i]) >>> 1);
            else                 lut_sum = lut_sum - (int'(b_cur[i]) >>> 1);
        end
    end
    assign lut_out = lut_sum[10:0];

    typedef struct packed {
        logic [3:0][7:0]    a;
        logic [3:0][7:0]    b;
        logic signed [31:0] bhs;
        logic signed [31:0] exp;   // corrected result
        logic [2:0]         faddr; // first RUN cycle address
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3,
                           input int bhs, input int exp, input logic [2:0] faddr);
        vecs[idx].a     = {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
        vecs[idx].b     = {b3[7:0], b2[7:0], b1[7:0], b0[7:0]};
        vecs[idx].bhs   = bhs;
        vecs[idx].exp   = exp;
        vecs[idx].faddr = faddr;
    endtask

    task automatic drive_vec(input int idx);
        for (int i = 0; i < 4; i++) begin
            A_in[i]  = vecs[idx].a[i];
            b_cur[i] = vecs[idx].b[i];
        end
        b_half_sum = vecs[idx].bhs[10:0];
    endtask

    function automatic longint expected(input int idx);
        return longint'(vecs[idx].exp) + ((CORR != 0) ? 0 : longint'(vecs[idx].bhs));
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic run_vec(input int idx);
        int cnt;
        drive_vec(idx);
        in_valid = 1'b1;
        chk($sformatf("v%0d in_ready", idx), in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 1;
        chk($sformatf("v%0d first_addr", idx), addr_array, vecs[idx].faddr);
        chk($sformatf("v%0d gen_done", idx), gen_done, 1);
        chk($sformatf("v%0d in_ready_busy", idx), in_ready, 0);
        while (!out_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk($sformatf("v%0d latency", idx), cnt, LAT);
        chk($sformatf("v%0d result", idx), result, expected(idx));
        chk($sformatf("v%0d gen_done_done", idx), gen_done, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("v%0d back_idle", idx), {in_ready, out_valid}, 2'b10);
    endtask

    initial begin : main
        int  cnt;
        logic seen;

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            A_in[i]  = '0;
            b_cur[i] = '0;
        end
        b_half_sum = '0;

        set_vec(0, 1, 1, 1, 1,        2, 2, 2, 2,             4,    8,      3'b111);
        set_vec(1, -128, 127, 0, -1,  2, 4, -6, 8,            4,    244,    3'b100);
        set_vec(2, -128, -128, -128, -128, 126, 126, 126, 126, 252, -64512, 3'b111);
        set_vec(3, 5, -3, 7, -8,      10, -20, 30, -40,       -10,  640,    3'b010);
        set_vec(4, -1, -1, -1, -1,    2, 2, 2, 2,             4,    -8,     3'b111);
        set_vec(5, 127, 127, 127, 127, -128, -128, -128, -128, -256, -65024, 3'b111);
        set_vec(6, 3, -5, 1, 2,       3, -7, 5, 9,            3,    66,     3'b110);

        #3;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset gen_done", gen_done, 0);
        chk("reset addr", addr_array, 0);
        chk("reset result", result, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            run_vec(v);
            @(negedge clk);
        end

        // Consumer back-pressure in DONE, plus a stray in_valid pulse during RUN
        drive_vec(1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) A_in[i] = 8'sd1;
        b_half_sum = 11'sd4;
        in_valid = 1'b1;
        chk("bp in_ready_run", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 4;
        while (!out_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("bp latency", cnt, LAT);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp result_hold%0d", i), result, expected(1));
            chk($sformatf("bp valid_hold%0d", i), {out_valid, in_ready}, 2'b10);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp back_idle", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | gen_done | out_valid;
        end
        chk("bp pulse_not_captured", seen, 0);

        // Reset during the third RUN cycle
        drive_vec(1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstrun gen_done_before", gen_done, 1);
        rst = 1'b0;
        #1;
        chk("rstrun in_ready", in_ready, 1);
        chk("rstrun gen_done", gen_done, 0);
        chk("rstrun addr", addr_array, 0);
        chk("rstrun out_valid", out_valid, 0);
        chk("rstrun result", result, 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            seen = seen | out_valid | gen_done;
        end
        chk("rstrun no_output", seen, 0);
        run_vec(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
